// File: rtl/cgp_pkg.sv
// Shared types and helpers for the CGP evolution datapath: the fitness
// controller state machine and the fitness word width used by the GA engine.
package cgp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        FIN
    } fit_state_t;

    // Settle counter width; the settle time is limited to 1..15 cycles.
    localparam int unsigned SETTLE_CW = 4;

    // Bits needed to hold a count of 0..(2**in_w)*out_w matching bits.
    function automatic int unsigned fit_width(input int unsigned in_w, input int unsigned out_w);
        return $clog2((2 ** in_w) * out_w + 1);
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational ones counter over a W-bit vector.
module popcount #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0]           bits_i,
    output logic [$clog2(W+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(W + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/cgp_fitness_eval.sv
// Sweeps every input vector through a LUT grid, waits a settle time per vector
// and counts grid output bits that agree with the target truth table.
module cgp_fitness_eval
    import cgp_pkg::*;
#(
    parameter int unsigned IN     = 4,
    parameter int unsigned OUT    = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [(2**IN)*OUT-1:0]          target,
    output logic [IN-1:0]                   grid_inp,
    input  logic [OUT-1:0]                  grid_out,
    output logic                            busy,
    output logic                            done,
    output logic [fit_width(IN, OUT)-1:0]   fitness,
    output logic                            perfect
);

    localparam int unsigned NV = 2 ** IN;
    localparam int unsigned TW = NV * OUT;
    localparam int unsigned FW = fit_width(IN, OUT);
    localparam int unsigned PW = $clog2(OUT + 1);
    localparam int unsigned CW = SETTLE_CW;

    fit_state_t     state_q;
    logic [IN-1:0]  vec_q;
    logic [CW-1:0]  cnt_q;
    logic [FW-1:0]  acc_q;
    logic [IN-1:0]  grid_inp_q;
    logic           busy_q;
    logic           done_q;
    logic [FW-1:0]  fitness_q;
    logic           perfect_q;

    logic [OUT-1:0] tgt_c;
    logic [PW-1:0]  match_cnt_c;
    logic [FW-1:0]  acc_d;

    assign tgt_c = target[vec_q * OUT +: OUT];
    assign acc_d = acc_q + FW'(match_cnt_c);

    popcount #(.W(OUT)) u_popcount (
        .bits_i  (~(grid_out ^ tgt_c)),
        .count_o (match_cnt_c)
    );

    // Sequencer; results are written on the SAMPLE->FIN edge so they appear with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            grid_inp_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fitness_q  <= '0;
            perfect_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q    <= WAIT;
                        vec_q      <= '0;
                        acc_q      <= '0;
                        cnt_q      <= CW'(SETTLE - 1);
                        grid_inp_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        grid_inp_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        grid_inp_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (vec_q == IN'(NV - 1)) begin
                        state_q   <= FIN;
                        acc_q     <= acc_d;
                        fitness_q <= acc_d;
                        perfect_q <= (acc_d == FW'(TW));
                        done_q    <= 1'b1;
                    end else begin
                        state_q    <= WAIT;
                        acc_q      <= acc_d;
                        vec_q      <= vec_q + IN'(1);
                        grid_inp_q <= vec_q + IN'(1);
                        cnt_q      <= CW'(SETTLE - 1);
                    end
                end
                FIN: begin
                    state_q    <= IDLE;
                    grid_inp_q <= '0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    grid_inp_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign grid_inp = grid_inp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fitness  = fitness_q;
    assign perfect  = perfect_q;

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Bench for cgp_fitness_eval: a timing/score model checked every cycle plus pinned literals.
module tb_cgp_fitness_eval;

    localparam int unsigned IN  = 4;
    localparam int unsigned OUT = 4;
    localparam int unsigned NV  = 16;
    localparam int unsigned TW  = 64;
    localparam int unsigned FW  = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_a, abort_a, start_b, abort_b;
    logic [TW-1:0] target;
    logic [IN-1:0] inp_a, inp_b;
    logic [OUT-1:0] out_a, out_b;
    logic busy_a, done_a, perf_a, busy_b, done_b, perf_b;
    logic [FW-1:0] fit_a, fit_b;

    cgp_fitness_eval #(.IN(IN), .OUT(OUT), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .target(target),
        .grid_inp(inp_a), .grid_out(out_a), .busy(busy_a), .done(done_a),
        .fitness(fit_a), .perfect(perf_a)
    );

    cgp_fitness_eval #(.IN(IN), .OUT(OUT), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .target(target),
        .grid_inp(inp_b), .grid_out(out_b), .busy(busy_b), .done(done_b),
        .fitness(fit_b), .perfect(perf_b)
    );

    // Grid models: A is combinational identity, B identity with one register of latency.
    assign out_a = inp_a;
    always @(posedge clk) out_b <= inp_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state for the run in progress
    int t0 = 0;
    bit running = 1'b0;
    bit sel_b = 1'b0;
    int settle = 2;
    int abort_cyc = -1;
    int last_fit = 0, new_fit = 0;
    bit last_perf = 1'b0, new_perf = 1'b0;
    int done_rel = -1;
    int done_cnt = 0;
    int inp_seen [0:63];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_fit(input logic [TW-1:0] tgt);
        int n;
        n = 0;
        for (int v = 0; v < NV; v++)
            for (int b = 0; b < OUT; b++)
                if (((v >> b) & 1) == int'(tgt[v*OUT + b])) n++;
        return n;
    endfunction

    // Per-cycle compare of the selected DUT against the model.
    always @(negedge clk) begin
        int rel, endc, last_drv, e_fit, e_perf, a_busy, a_done, a_inp, a_fit, a_perf;
        bit act;
        if (rst_n) begin
            rel = cyc - t0;
            endc = NV * (settle + 1) + 1;
            last_drv = NV * (settle + 1);
            act = running && rel >= 1 && rel <= endc && !(abort_cyc >= 0 && rel > abort_cyc);
            if (running && abort_cyc < 0 && rel >= endc) begin
                e_fit = new_fit;
                e_perf = int'(new_perf);
            end else begin
                e_fit = last_fit;
                e_perf = int'(last_perf);
            end
            a_busy = sel_b ? int'(busy_b) : int'(busy_a);
            a_done = sel_b ? int'(done_b) : int'(done_a);
            a_inp  = sel_b ? int'(inp_b)  : int'(inp_a);
            a_fit  = sel_b ? int'(fit_b)  : int'(fit_a);
            a_perf = sel_b ? int'(perf_b) : int'(perf_a);
            chk($sformatf("busy@%0d", rel), a_busy, int'(act));
            chk($sformatf("done@%0d", rel), a_done, int'(act && rel == endc));
            chk($sformatf("fitness@%0d", rel), a_fit, e_fit);
            chk($sformatf("perfect@%0d", rel), a_perf, e_perf);
            if (act && rel <= last_drv)
                chk($sformatf("grid_inp@%0d", rel), a_inp, (rel - 1) / (settle + 1));
            else if (!act)
                chk($sformatf("grid_inp_idle@%0d", rel), a_inp, 0);
            if (running && rel >= 0 && rel < 64) inp_seen[rel] = a_inp;
            if (running && a_done == 1) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
            end
        end
    end

    task automatic run(input bit use_b, input logic [TW-1:0] tgt, input int s,
                       input int ab, input int xs, input int stop_at);
        int endc, last;
        endc = NV * (s + 1) + 1;
        last = (stop_at >= 0) ? stop_at : endc + 2;
        target = tgt;
        sel_b = use_b;
        settle = s;
        new_fit = model_fit(tgt);
        new_perf = (new_fit == int'(TW));
        abort_cyc = ab;
        t0 = cyc;
        done_rel = -1;
        done_cnt = 0;
        running = 1'b1;
        for (int r = 0; r <= last; r++) begin
            start_a = !use_b && (r == 0 || r == xs);
            start_b =  use_b && (r == 0 || r == xs);
            abort_a = !use_b && (r == ab);
            abort_b =  use_b && (r == ab);
            @(posedge clk);
            #1;
        end
        start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        if (stop_at < 0) begin
            if (ab < 0) begin
                last_fit = new_fit;
                last_perf = new_perf;
            end
            running = 1'b0;
        end
    endtask

    logic [TW-1:0] t_id, t_zero, t_flip;

    initial begin
        for (int v = 0; v < NV; v++) t_id[v*OUT +: OUT] = OUT'(v);
        t_zero = '0;
        t_flip = t_id;
        t_flip[5*OUT + 2] = ~t_flip[5*OUT + 2];
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        target = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_fitness", int'(fit_a), 0);
        chk("rst_perfect", int'(perf_a), 0);
        chk("rst_grid_inp", int'(inp_a), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run(1'b0, t_zero, 2, -1, -1, -1);
        chk("zeros_fitness", int'(fit_a), 32);
        chk("zeros_perfect", int'(perf_a), 0);

        run(1'b0, t_flip, 2, -1, -1, -1);
        chk("flip_fitness", int'(fit_a), 63);
        for (int c = 16; c <= 18; c++) chk($sformatf("flip_inp5@%0d", c), inp_seen[c], 5);

        run(1'b0, t_id, 2, -1, -1, -1);
        chk("id_done_cycle", done_rel, 49);
        chk("id_fitness", int'(fit_a), 64);
        chk("id_perfect", int'(perf_a), 1);

        run(1'b0, t_zero, 2, 20, -1, 60);
        running = 1'b0;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_fitness_kept", int'(fit_a), 64);

        run(1'b0, t_zero, 2, -1, 10, -1);
        chk("restart_done_cycle", done_rel, 49);
        chk("restart_done_count", done_cnt, 1);
        chk("restart_fitness", int'(fit_a), 32);

        run(1'b0, t_id, 2, -1, -1, 25);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_fitness", int'(fit_a), 0);
        chk("midrst_perfect", int'(perf_a), 0);
        chk("midrst_grid_inp", int'(inp_a), 0);
        running = 1'b0;
        last_fit = 0;
        last_perf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run(1'b1, t_id, 1, -1, -1, -1);
        chk("s1_done_cycle", done_rel, 33);
        chk("s1_fitness", int'(fit_b), 64);
        chk("s1_perfect", int'(perf_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cgp_fitness_eval.md
# cgp_fitness_eval

Sequencing controller that scores one configured LUT grid against a target truth table. It sweeps every input vector into the grid's `inp` bus and waits a programmable settle time for the combinational mesh. It then samples the grid's `out` bus and accumulates the count of output bits matching the target. It sits between the genetic-algorithm engine, which loads `saidas_LE`/`out_chrom` and pulses `start`, and the grid instance.

## Interface
Parameters:
- `IN`, 4: grid primary inputs; 2**IN vectors are swept.
- `OUT`, 4: grid outputs compared per vector.
- `SETTLE`, 2: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an evaluation; honoured only in IDLE.
- `abort`  in  1  cancel a running evaluation.
- `target`  in  (2**IN)*OUT  expected outputs; slice `[v*OUT +: OUT]` is the response to vector v. Must be stable while `busy`.
- `grid_inp`  out  IN  vector driven to the grid `inp`.
- `grid_out`  in  OUT  grid `out`, sampled once per vector.
- `busy`  out  1  high in WAIT, SAMPLE, FIN.
- `done`  out  1  one-cycle pulse: `fitness` updated.
- `fitness`  out  FW  matching bits of the last completed evaluation, where FW = $clog2((2**IN)*OUT+1).
- `perfect`  out  1  `fitness` == (2**IN)*OUT; updated with `fitness`.

## Operation
- State machine: IDLE, WAIT, SAMPLE, FIN.
- IDLE:
  - `start` & !`abort` → WAIT.
  - On that transition: vec←0, acc←0, cnt←SETTLE-1.
  - `start` is ignored in every other state.
- WAIT:
  - `grid_inp`=vec.
  - cnt≠0 → cnt−1.
  - cnt==0 → SAMPLE.
- SAMPLE:
  - acc ← acc + popcount(~(`grid_out` ^ target[vec*OUT +: OUT])).
  - vec==2**IN−1 → FIN.
  - Otherwise vec+1, cnt←SETTLE-1, → WAIT.
- FIN:
  - `fitness`←acc; `perfect`←(acc==(2**IN)*OUT).
  - `done`=1; → IDLE.
- `abort` in WAIT or SAMPLE:
  - → IDLE next cycle.
  - No `done`; `fitness`/`perfect` keep their previous values.
  - The partial acc is discarded.
- `abort` in FIN is ignored: completion wins.
- `abort` in IDLE has no effect and blocks a coincident `start`.
- Arithmetic:
  - acc is FW bits wide and cannot overflow.
  - The popcount result is zero-extended to FW bits.
  - vec is IN bits wide; no wrap occurs because FIN is taken at the last vector.
- `grid_inp` returns to 0 in IDLE.
- `grid_out` is treated as combinational from `grid_inp`. Any settling beyond SETTLE cycles is the integrator's responsibility.

## Timing
- Reset values: state IDLE, `grid_inp`=0, `busy`=0, `done`=0, `fitness`=0, `perfect`=0, vec/cnt/acc=0.
- Reset asserted mid-evaluation returns everything to these values immediately (asynchronous reset). No `done` is produced.
- Let cycle 0 be the cycle in which `start` is sampled in IDLE:
  - Vector v is driven from cycle 1+v*(SETTLE+1) through its SAMPLE cycle.
  - SAMPLE for vector v occurs at cycle (v+1)*(SETTLE+1).
  - `done`=1 in cycle (2**IN)*(SETTLE+1)+1.
  - `fitness`/`perfect` are visible in the same cycle as `done`.
  - `busy` falls in the cycle after `done`.
- Back-to-back: `start` may be asserted in the cycle after `done` (IDLE) and is accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `cgp_pkg`:
  - state enum `fit_state_t` {IDLE, WAIT, SAMPLE, FIN}.
  - function `fit_width(IN, OUT)` returning FW, reused by the GA engine's fitness comparators.
- One sub-module: `popcount #(W)`, combinational W-bit ones counter producing $clog2(W+1) bits. It is instantiated with W=OUT.
- The grid itself is instantiated by the top level, not inside this block.

## Test plan
- IN=4, OUT=4, SETTLE=2; bench model `grid_out`=`grid_inp`; target slice v = v:
  - `done` at cycle 49.
  - `fitness`=64, `perfect`=1.
- Same model, target all zeros:
  - `fitness`=32 (ones in 0..15 over 4 bits), `perfect`=0.
- Identity target with bit 2 of vector 5 flipped:
  - `fitness`=63.
  - `grid_inp` observed as 5 in cycles 16–18.
- After a 64-result run, pulse `abort` at cycle 20 of a new run:
  - `busy`=0 at cycle 21.
  - No `done`; `fitness` stays 64.
- `start` pulsed at cycle 10 while busy is ignored: `done` still at 49 only.
  - Then assert `rst_n`=0 mid-run: all outputs read 0 at once.
- SETTLE=1 with a bench grid model that registers its output once (1-cycle latency):
  - Identity target gives `fitness`=64.
  - `done` at cycle 33.
